snake_body: RTL and testbench
=============================

# snake_body

Snake movement and body-storage engine: holds up to MAX_LEN segment coordinates, advances the snake one cell per `move_tick`, grows on the fruit block's `increase_size` pulse, and detects wall and self collisions. It produces the `head_x/head_y` and `head_x1/head_y1` coordinates the fruit block consumes. It also serves segment coordinates to the VGA draw path through a random-access read port.

## Interface
- MAX_LEN, 32: segment capacity; power of two, at most 32.
- GRID_W, 160: playfield width in cells; legal x is 0..GRID_W-1.
- GRID_H, 120: playfield height in cells; legal y is 0..GRID_H-1.
- START_X, 80: head x at reset.
- START_Y, 60: head y at reset.
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- move_tick  in  1  one-cycle pulse requesting a move.
- dir_in  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
- grow  in  1  one-cycle pulse from fruit `increase_size`.
- rd_idx  in  5  segment index for the draw port.
- head_x, head_y  out  8 each  segment 0, the current head.
- head_x1, head_y1  out  8 each  segment 1, the previous head.
- seg_x, seg_y  out  8 each  segment[rd_idx]; combinational.
- seg_valid  out  1  high when rd_idx < length.
- length  out  6  current segment count, 3..MAX_LEN.
- busy  out  1  high while in CHECK.
- game_over  out  1  sticky collision flag.

## Operation
- **Reset state.**
  - seg[i] = (START_X-i, START_Y) for i = 0..2; all other segments = (0,0).
  - length = 3, cur_dir = 01, grow_pend = 0, game_over = 0, busy = 0.
  - FSM enters IDLE.
- **grow_pend.**
  - Set by `grow` in any state except DEAD.
  - Cleared only when consumed by a move.
  - Multiple grow pulses between two moves count once.
- **IDLE, move_tick = 1:**
  - Direction update: if dir_in is the exact reverse of cur_dir (00↔10, 01↔11), cur_dir is kept. Otherwise cur_dir = dir_in.
  - Compute next head from cur_dir, using the updated value.
  - Wall check: the move is a wall hit if x = 0 moving left, x = GRID_W-1 moving right, y = 0 moving up, or y = GRID_H-1 moving down.
  - On a wall hit: the segments are not modified, game_over = 1, and the FSM goes to DEAD.
  - Otherwise the body shifts: seg[i] = seg[i-1] for i = 1..MAX_LEN-1, and seg[0] = next head.
  - Growth: if grow_pend is set (or `grow` is high in the same cycle) and length < MAX_LEN, then length = length+1. Growing at length = MAX_LEN is discarded. In both cases grow_pend is cleared.
  - The FSM then goes to CHECK with scan index k = 1.
- **CHECK** (one compare per cycle):
  - If seg[k] equals seg[0], then game_over = 1 and the FSM goes to DEAD.
  - Else if k = length-1, the FSM goes to IDLE.
  - Else k = k+1.
  - The scan covers segments 1..length-1 only.
  - move_tick received in CHECK is dropped, not queued.
- **DEAD:** all inputs are ignored except resetn; the segments are frozen and the draw port still works.
- **Coordinate arithmetic:** 8-bit unsigned. The wall check prevents any wrap-around, so coordinates never wrap.

## Timing
- Outputs head_*, head_*1, length, game_over and busy are registered.
- **Move latency:** move_tick in IDLE at edge N gives new head_x/head_y and length after edge N, and busy = 1 after edge N.
- **CHECK duration:** length-1 cycles. busy falls after edge N+length-1 when no collision occurs.
- **Collision at scan index k:** game_over is set after edge N+k, and busy = 0 from then on.
- **Wall hit:** game_over is set after edge N and busy stays 0.
- Earliest accepted next move_tick is at edge N+length.
- seg_x/seg_y/seg_valid reflect the registered array the same cycle rd_idx changes.
- Asynchronous reset mid-CHECK or mid-move immediately restores the reset state; no partial shift survives.

## Test plan
- **Reset and straight move:** release reset, pulse move_tick with dir_in=01 → head=(81,60), head1=(80,60), length=3, busy high for 2 cycles, game_over=0.
- **Reversal ignored:** with cur_dir=01, pulse move_tick with dir_in=11 → head x increments (81→82) and cur_dir stays right.
- **Growth:** pulse grow, then two cycles later move_tick → length=4 and seg[3]=old seg[2]. Also grow and move_tick in the same cycle → length increments on that move. Also two grow pulses before one move → +1 only.
- **Wall:** from reset, issue 79 right moves (head x=159), then one more right move → game_over=1 after that edge, head stays (159,60), and later move_ticks have no effect.
- **Self-collision:** grow to length 5, then move up, left, down in turn → game_over set during CHECK at the matching index. Also pulse move_tick during busy → it is dropped.
- **Saturation and reset:** grow to 32, pulse grow and then move → length stays 32. Assert resetn low mid-CHECK → length=3, head=(80,60) and busy=0 immediately.

Source files
------------

// File: rtl/snake_body.sv
// Snake movement and body storage: shifts the segment array on each accepted
// move, grows on request, and scans the body for wall and self collisions.
module snake_body #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned GRID_W  = 160,
    parameter int unsigned GRID_H  = 120,
    parameter int unsigned START_X = 80,
    parameter int unsigned START_Y = 60
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       move_tick,
    input  logic [1:0] dir_in,
    input  logic       grow,
    input  logic [4:0] rd_idx,
    output logic [7:0] head_x,
    output logic [7:0] head_y,
    output logic [7:0] head_x1,
    output logic [7:0] head_y1,
    output logic [7:0] seg_x,
    output logic [7:0] seg_y,
    output logic       seg_valid,
    output logic [5:0] length,
    output logic       busy,
    output logic       game_over
);

    localparam int unsigned IW      = $clog2(MAX_LEN);
    localparam logic [5:0]  LP_MAX  = 6'(MAX_LEN);
    localparam logic [7:0]  LP_XMAX = 8'(GRID_W - 1);
    localparam logic [7:0]  LP_YMAX = 8'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DEAD
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_seg_x [MAX_LEN];
    logic [7:0] r_seg_y [MAX_LEN];
    logic [5:0] r_len;
    logic [1:0] r_dir;
    logic       r_grow_pend;
    logic       r_game_over;
    logic [4:0] r_k;

    logic [1:0] w_dir;
    logic [7:0] w_nx;
    logic [7:0] w_ny;
    logic       w_wall;
    logic       w_accept;
    logic       w_shift;
    logic       w_hit;
    logic       w_scan_end;

    // A request for the exact reverse direction keeps the current heading.
    always_comb begin
        w_dir  = (dir_in == (r_dir ^ 2'b10)) ? r_dir : dir_in;
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        case (w_dir)
            2'b00: begin
                w_wall = (r_seg_y[0] == 8'd0);
                w_ny   = r_seg_y[0] - 8'd1;
            end
            2'b01: begin
                w_wall = (r_seg_x[0] == LP_XMAX);
                w_nx   = r_seg_x[0] + 8'd1;
            end
            2'b10: begin
                w_wall = (r_seg_y[0] == LP_YMAX);
                w_ny   = r_seg_y[0] + 8'd1;
            end
            default: begin
                w_wall = (r_seg_x[0] == 8'd0);
                w_nx   = r_seg_x[0] - 8'd1;
            end
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && move_tick;
    assign w_shift    = w_accept && !w_wall;
    assign w_hit      = (r_seg_x[r_k[IW-1:0]] == r_seg_x[0]) &&
                        (r_seg_y[r_k[IW-1:0]] == r_seg_y[0]);
    assign w_scan_end = ({1'b0, r_k} == (r_len - 6'd1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_wall ? S_DEAD : S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_hit) begin
                    w_state_nxt = S_DEAD;
                end else if (w_scan_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_DEAD;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < 3) ? 8'(START_X - i) : '0;
                r_seg_y[i] <= (i < 3) ? 8'(START_Y) : '0;
            end
            r_len       <= 6'd3;
            r_dir       <= 2'b01;
            r_grow_pend <= 1'b0;
            r_game_over <= 1'b0;
            r_k         <= 5'd1;
        end else begin
            if (w_accept) begin
                r_dir <= w_dir;
            end
            if (w_shift) begin
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                if ((r_grow_pend || grow) && (r_len < LP_MAX)) begin
                    r_len <= r_len + 6'd1;
                end
                r_k <= 5'd1;
            end else if ((r_state == S_CHECK) && !w_hit && !w_scan_end) begin
                r_k <= r_k + 5'd1;
            end
            // A grow arriving with the consuming move is absorbed by that move.
            if (r_state != S_DEAD) begin
                if (w_shift) begin
                    r_grow_pend <= 1'b0;
                end else if (grow) begin
                    r_grow_pend <= 1'b1;
                end
            end
            if ((w_accept && w_wall) || ((r_state == S_CHECK) && w_hit)) begin
                r_game_over <= 1'b1;
            end
        end
    end

    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign head_x1   = r_seg_x[1];
    assign head_y1   = r_seg_y[1];
    assign seg_x     = r_seg_x[rd_idx[IW-1:0]];
    assign seg_y     = r_seg_y[rd_idx[IW-1:0]];
    assign seg_valid = ({1'b0, rd_idx} < r_len);
    assign length    = r_len;
    assign busy      = (r_state == S_CHECK);
    assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed scenarios plus a random walk, all checked
// against a queue-based model of the snake.
module tb_snake_body;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] dir_in = 2'b01;
    logic       grow = 1'b0;
    logic [4:0] rd_idx = '0;
    logic [7:0] head_x, head_y, head_x1, head_y1, seg_x, seg_y;
    logic       seg_valid, busy, game_over;
    logic [5:0] length;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    snake_body #(
        .MAX_LEN(32),
        .GRID_W (160),
        .GRID_H (120),
        .START_X(80),
        .START_Y(60)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .move_tick(move_tick),
        .dir_in   (dir_in),
        .grow     (grow),
        .rd_idx   (rd_idx),
        .head_x   (head_x),
        .head_y   (head_y),
        .head_x1  (head_x1),
        .head_y1  (head_y1),
        .seg_x    (seg_x),
        .seg_y    (seg_y),
        .seg_valid(seg_valid),
        .length   (length),
        .busy     (busy),
        .game_over(game_over)
    );

    // Model: the body is a fixed-depth queue; each move pushes a head and drops the tail.
    int qx[$];
    int qy[$];
    int mlen, mdir, mexp_cyc;
    bit mpend, mdead;

    wire [38:0] w_obs = {head_x, head_y, head_x1, head_y1, length, game_over};

    function automatic logic [38:0] model_vec();
        return {8'(qx[0]), 8'(qy[0]), 8'(qx[1]), 8'(qy[1]), 6'(mlen), 1'(mdead)};
    endfunction

    task automatic model_reset();
        qx = {};
        qy = {};
        for (int i = 0; i < 32; i++) begin
            qx.push_back(i < 3 ? 80 - i : 0);
            qy.push_back(i < 3 ? 60 : 0);
        end
        mlen = 3; mdir = 1; mpend = 0; mdead = 0; mexp_cyc = 0;
    endtask

    task automatic model_move(input int d, input bit g);
        int nx, ny, k;
        mexp_cyc = 0;
        if (mdead) return;
        if (d == (mdir ^ 2)) d = mdir;
        mdir = d;
        nx = qx[0] + (d == 1 ? 1 : 0) - (d == 3 ? 1 : 0);
        ny = qy[0] + (d == 2 ? 1 : 0) - (d == 0 ? 1 : 0);
        if (nx < 0 || nx >= 160 || ny < 0 || ny >= 120) begin
            mdead = 1;
            return;
        end
        qx.push_front(nx); void'(qx.pop_back());
        qy.push_front(ny); void'(qy.pop_back());
        if ((mpend || g) && mlen < 32) mlen++;
        mpend = 0;
        k = 0;
        for (int i = mlen - 1; i >= 1; i--)
            if (qx[i] == qx[0] && qy[i] == qy[0]) k = i;
        if (k != 0) begin
            mdead = 1;
            mexp_cyc = k;
        end else begin
            mexp_cyc = mlen - 1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        move_tick = 1'b0;
        grow = 1'b0;
        #2;
        resetn = 1'b1;
        model_reset();
        step();
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        step();
        grow = 1'b0;
        if (!mdead) mpend = 1;
    endtask

    // Issues one move and returns how many cycles busy stayed high after it.
    task automatic do_move(input logic [1:0] d, input bit g, input bit drop_tick, output int cyc);
        model_move(int'(d), g);
        move_tick = 1'b1;
        dir_in = d;
        grow = g;
        step();
        move_tick = 1'b0;
        grow = 1'b0;
        cyc = 0;
        if (drop_tick && busy) begin
            move_tick = 1'b1;
            dir_in = 2'($urandom_range(0, 3));
            step();
            move_tick = 1'b0;
            cyc = 1;
        end
        while (busy && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (w_obs !== {8'd80, 8'd60, 8'd79, 8'd60, 6'd3, 1'b0}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", w_obs, {8'd80, 8'd60, 8'd79, 8'd60, 6'd3, 1'b0});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 5'(i);
            #1;
            checks++;
            if ({seg_x, seg_y, seg_valid} !== {8'(qx[i]), 8'(qy[i]), 1'(i < mlen)}) begin
                errors++; $display("FAIL reset_seg[%0d]: got %0d,%0d,%b expected %0d,%0d,%b",
                                   i, seg_x, seg_y, seg_valid, qx[i], qy[i], i < mlen);
            end
        end
    endtask

    task automatic test_straight();
        int cyc;
        do_move(2'b01, 0, 0, cyc);
        checks++;
        if (w_obs !== {8'd81, 8'd60, 8'd80, 8'd60, 6'd3, 1'b0}) begin
            errors++; $display("FAIL straight_move: got %h expected %h", w_obs, {8'd81, 8'd60, 8'd80, 8'd60, 6'd3, 1'b0});
        end
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL straight_busy_cycles: got %0d expected 2", cyc);
        end
    endtask

    task automatic test_reversal();
        int cyc;
        do_move(2'b11, 0, 0, cyc);
        checks++;
        if (head_x !== 8'd82 || w_obs !== model_vec()) begin
            errors++; $display("FAIL reversal_first: got %h expected %h", w_obs, model_vec());
        end
        do_move(2'b11, 0, 0, cyc);
        checks++;
        if (head_x !== 8'd83 || w_obs !== model_vec()) begin
            errors++; $display("FAIL reversal_kept_right: got %h expected %h", w_obs, model_vec());
        end
    endtask

    task automatic test_growth();
        int cyc, old_x, old_y;
        old_x = qx[2];
        old_y = qy[2];
        pulse_grow();
        step();
        do_move(2'b01, 0, 0, cyc);
        rd_idx = 5'd3;
        #1;
        checks++;
        if (length !== 6'd4 || {seg_x, seg_y, seg_valid} !== {8'(old_x), 8'(old_y), 1'b1}) begin
            errors++; $display("FAIL grow_pending: got len %0d seg3 %0d,%0d expected len 4 seg3 %0d,%0d",
                               length, seg_x, seg_y, old_x, old_y);
        end
        checks++;
        if (cyc !== mexp_cyc) begin
            errors++; $display("FAIL grow_busy_cycles: got %0d expected %0d", cyc, mexp_cyc);
        end
        do_move(2'b01, 1, 0, cyc);
        checks++;
        if (length !== 6'd5 || w_obs !== model_vec()) begin
            errors++; $display("FAIL grow_same_cycle: got %h expected %h", w_obs, model_vec());
        end
        pulse_grow();
        pulse_grow();
        do_move(2'b01, 0, 0, cyc);
        checks++;
        if (length !== 6'd6 || w_obs !== model_vec()) begin
            errors++; $display("FAIL grow_double_pulse: got %h expected %h", w_obs, model_vec());
        end
    endtask

    task automatic test_wall();
        int cyc;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 79; i++) begin
            do_move(2'b01, 0, 0, cyc);
            if (cyc != 2 || w_obs !== model_vec()) bad++;
        end
        checks++;
        if (head_x !== 8'd159 || bad != 0) begin
            errors++; $display("FAIL wall_approach: got x %0d bad_moves %0d expected x 159 bad_moves 0", head_x, bad);
        end
        do_move(2'b01, 0, 0, cyc);
        checks++;
        if (w_obs !== {8'd159, 8'd60, 8'd158, 8'd60, 6'd3, 1'b1} || busy !== 1'b0 || cyc !== 0) begin
            errors++; $display("FAIL wall_hit: got %h busy %b cyc %0d expected %h busy 0 cyc 0",
                               w_obs, busy, cyc, {8'd159, 8'd60, 8'd158, 8'd60, 6'd3, 1'b1});
        end
        pulse_grow();
        do_move(2'b10, 1, 0, cyc);
        checks++;
        if (w_obs !== model_vec() || busy !== 1'b0) begin
            errors++; $display("FAIL dead_frozen: got %h busy %b expected %h busy 0", w_obs, busy, model_vec());
        end
    endtask

    task automatic test_self_collision();
        int cyc;
        do_reset();
        do_move(2'b01, 1, 0, cyc);
        do_move(2'b01, 1, 0, cyc);
        checks++;
        if (length !== 6'd5) begin
            errors++; $display("FAIL collide_setup_len: got %0d expected 5", length);
        end
        do_move(2'b00, 0, 1, cyc);
        checks++;
        if (w_obs !== model_vec() || cyc !== mexp_cyc) begin
            errors++; $display("FAIL dropped_tick: got %h cyc %0d expected %h cyc %0d", w_obs, cyc, model_vec(), mexp_cyc);
        end
        do_move(2'b11, 0, 0, cyc);
        do_move(2'b10, 0, 0, cyc);
        checks++;
        if (w_obs !== {8'd81, 8'd60, 8'd81, 8'd59, 6'd5, 1'b1} || cyc !== 4 || busy !== 1'b0) begin
            errors++; $display("FAIL self_collision: got %h cyc %0d busy %b expected %h cyc 4 busy 0",
                               w_obs, cyc, busy, {8'd81, 8'd60, 8'd81, 8'd59, 6'd5, 1'b1});
        end
    endtask

    task automatic test_saturation();
        int cyc;
        do_reset();
        for (int i = 0; i < 29; i++) do_move(2'b01, 1, 0, cyc);
        checks++;
        if (length !== 6'd32 || cyc !== 31) begin
            errors++; $display("FAIL grow_to_max: got len %0d cyc %0d expected len 32 cyc 31", length, cyc);
        end
        pulse_grow();
        do_move(2'b01, 0, 0, cyc);
        checks++;
        if (length !== 6'd32 || w_obs !== model_vec()) begin
            errors++; $display("FAIL saturation: got %h expected %h", w_obs, model_vec());
        end
        move_tick = 1'b1;
        dir_in = 2'b01;
        step();
        move_tick = 1'b0;
        step();
        step();
        resetn = 1'b0;
        #1;
        checks++;
        if (w_obs !== {8'd80, 8'd60, 8'd79, 8'd60, 6'd3, 1'b0} || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_check: got %h busy %b expected %h busy 0",
                               w_obs, busy, {8'd80, 8'd60, 8'd79, 8'd60, 6'd3, 1'b0});
        end
        #2;
        resetn = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_random();
        int cyc, idx, bad_state, bad_cyc, bad_seg;
        bit g;
        do_reset();
        bad_state = 0; bad_cyc = 0; bad_seg = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) pulse_grow();
            g = ($urandom_range(0, 2) == 0);
            do_move(2'($urandom_range(0, 3)), g, ($urandom_range(0, 4) == 0), cyc);
            if (w_obs !== model_vec()) bad_state++;
            if (cyc != mexp_cyc) bad_cyc++;
            idx = $urandom_range(0, 31);
            rd_idx = 5'(idx);
            #1;
            if (seg_valid !== 1'(idx < mlen)) bad_seg++;
            else if (idx < mlen && {seg_x, seg_y} !== {8'(qx[idx]), 8'(qy[idx])}) bad_seg++;
            if (mdead) do_reset();
        end
        checks++;
        if (bad_state != 0) begin
            errors++; $display("FAIL random_state: got %0d bad moves expected 0", bad_state);
        end
        checks++;
        if (bad_cyc != 0) begin
            errors++; $display("FAIL random_busy_cycles: got %0d bad moves expected 0", bad_cyc);
        end
        checks++;
        if (bad_seg != 0) begin
            errors++; $display("FAIL random_draw_port: got %0d bad reads expected 0", bad_seg);
        end
    endtask

    initial begin
        model_reset();
        step();
        test_reset();
        test_straight();
        test_reversal();
        test_growth();
        test_wall();
        test_self_collision();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
